// File: rtl/tlp_pkg.sv
// Shared definitions for the TLP transmit/receive schedulers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tlp_pkg;

  // Arbitration FSM encoding; every 2-bit value is a legal state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_t;

  // Cycles an untaken grant survives before it is revoked.
  localparam int DEF_GRANT_TIMEOUT = 64;
  // Minimum transmit buffers the core must report before a grant is issued.
  localparam int DEF_MIN_TBUF      = 1;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority selector: first set req bit strictly after index last, wrapping.
// Latency: purely combinational.
// Backpressure: none; caller decides whether to act on the selection.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         sel_oh,
  output logic [$clog2(N_REQ)-1:0] sel_idx,
  output logic                     sel_vld
);

  localparam int IW = $clog2(N_REQ);

  int            pos;
  logic [IW-1:0] pos_idx;

  // Walk last+1 .. last+N_REQ modulo N_REQ and keep the first requester found.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    sel_vld = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = int'(last) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      pos_idx = pos[IW-1:0];
      if (!sel_vld && req[pos_idx]) begin
        sel_vld         = 1'b1;
        sel_idx         = pos_idx;
        sel_oh[pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlp_tx_scheduler.sv
// Round-robin owner of the single TLP transmit interface with guard gap and grant watchdog.
// Latency: grant registered on the edge that samples req in IDLE; >=2 grant-free cycles between owners.
// Backpressure: no grant while trn_tbuf_av < MIN_TBUF; grant holds until driven[owner] or timeout.
module tlp_tx_scheduler
  import tlp_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
  parameter int MIN_TBUF      = DEF_MIN_TBUF
) (
  input  logic             trn_clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] driven,
  input  logic [5:0]       trn_tbuf_av,
  output logic [N_REQ-1:0] grant,
  output logic [2:0]       owner,
  output logic             busy,
  output logic             timeout_pulse,
  output logic             proto_err
);

  localparam int            IW         = $clog2(N_REQ);
  localparam int            TW         = $clog2(GRANT_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(GRANT_TIMEOUT - 1);
  localparam logic [5:0]    TBUF_MIN   = 6'(MIN_TBUF);
  localparam logic [IW-1:0] LAST_RST   = IW'(N_REQ - 1);

  sched_state_t     state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q, last_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             tpulse_q, tpulse_d;
  logic             perr_q, perr_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic [N_REQ-1:0] owner_mask;
  logic             tbuf_ok;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .last    (last_q),
    .sel_oh  (pick_oh),
    .sel_idx (pick_idx),
    .sel_vld (pick_vld)
  );

  assign owner_mask = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign tbuf_ok    = (trn_tbuf_av >= TBUF_MIN);

  // Next-state, grant, watchdog and protocol-error evaluation.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    last_d   = last_q;
    timer_d  = timer_q;
    tpulse_d = 1'b0;
    // Only the owner may drive outside IDLE; nobody may drive in IDLE.
    if (state_q == ST_IDLE) perr_d = perr_q | (|driven);
    else                    perr_d = perr_q | (|(driven & ~owner_mask));

    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_vld && tbuf_ok && (driven == '0)) begin
          grant_d = pick_oh;
          owner_d = pick_idx;
          last_d  = pick_idx;
          timer_d = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (driven[owner_q]) begin
          grant_d = '0;
          state_d = ST_BUSY;
        end else if (timer_q == TIMER_LAST) begin
          grant_d  = '0;
          tpulse_d = 1'b1;
          state_d  = ST_GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_BUSY: begin
        grant_d = '0;
        if (!driven[owner_q]) state_d = ST_GAP;
      end
      ST_GAP: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      last_q   <= LAST_RST;
      timer_q  <= '0;
      tpulse_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      timer_q  <= timer_d;
      tpulse_q <= tpulse_d;
      perr_q   <= perr_d;
    end
  end

  assign grant         = grant_q;
  assign owner         = 3'(owner_q);
  assign busy          = (state_q == ST_GRANT) || (state_q == ST_BUSY);
  assign timeout_pulse = tpulse_q;
  assign proto_err     = perr_q;

endmodule

// File: tb/tb_tlp_tx_scheduler.sv
// Directed bench for tlp_tx_scheduler: vector table plus a watchdog sequence.
// Latency: inputs applied at negedge, outputs compared at the following negedge.
// Backpressure: exercised through trn_tbuf_av and the driven handshake.
module tb_tlp_tx_scheduler;

  logic       trn_clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] driven;
  logic [5:0] trn_tbuf_av;
  logic [3:0] grant;
  logic [2:0] owner;
  logic       busy;
  logic       timeout_pulse;
  logic       proto_err;

  int checks = 0;
  int errors = 0;

  tlp_tx_scheduler #(
    .N_REQ         (4),
    .GRANT_TIMEOUT (8),
    .MIN_TBUF      (1)
  ) dut (
    .trn_clk       (trn_clk),
    .reset         (reset),
    .req           (req),
    .driven        (driven),
    .trn_tbuf_av   (trn_tbuf_av),
    .grant         (grant),
    .owner         (owner),
    .busy          (busy),
    .timeout_pulse (timeout_pulse),
    .proto_err     (proto_err)
  );

  always #5 trn_clk = ~trn_clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] drv;
    logic [5:0] tb;
    logic [3:0] g;
    logic [2:0] own;
    logic       bsy;
    logic       tp;
    logic       pe;
  } vec_t;

  vec_t tv[40];
  int   nv = 0;

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] dv,
                     input logic [5:0] tb, input logic [3:0] g, input logic [2:0] own,
                     input logic bsy, input logic tp, input logic pe);
    tv[nv] = '{r, rq, dv, tb, g, own, bsy, tp, pe};
    nv++;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  logic [3:0] g_log[12];
  logic       tp_log[12];
  logic [2:0] own_log[12];
  int         gcnt;
  int         tcnt;

  initial begin
    reset       = 1'b1;
    req         = '0;
    driven      = '0;
    trn_tbuf_av = 6'd8;

    // rst req drv tb | grant owner busy tpulse perr
    add(1, 4'b0000, 4'b0000, 8, 4'b0000, 0, 0, 0, 0); // reset values
    add(0, 4'b0010, 4'b0000, 8, 4'b0010, 1, 1, 0, 0); // single requester granted
    add(0, 4'b0010, 4'b0000, 8, 4'b0010, 1, 1, 0, 0);
    add(0, 4'b0010, 4'b0000, 8, 4'b0010, 1, 1, 0, 0);
    add(0, 4'b0010, 4'b0010, 8, 4'b0000, 1, 1, 0, 0); // driven -> BUSY, grant drops
    add(0, 4'b0000, 4'b0010, 8, 4'b0000, 1, 1, 0, 0);
    add(0, 4'b0000, 4'b0000, 8, 4'b0000, 1, 0, 0, 0); // GAP
    add(0, 4'b0000, 4'b0000, 8, 4'b0000, 1, 0, 0, 0); // IDLE
    add(0, 4'b1111, 4'b0000, 0, 4'b0000, 1, 0, 0, 0); // no buffers: no grant
    add(0, 4'b1111, 4'b0000, 0, 4'b0000, 1, 0, 0, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'b0100, 2, 1, 0, 0); // buffer appears: rotate to 2
    add(0, 4'b1111, 4'b0100, 1, 4'b0000, 2, 1, 0, 0);
    add(0, 4'b1111, 4'b0100, 1, 4'b0000, 2, 1, 0, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'b0000, 2, 0, 0, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'b0000, 2, 0, 0, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'b1000, 3, 1, 0, 0); // next in rotation: 3
    add(0, 4'b1111, 4'b1000, 1, 4'b0000, 3, 1, 0, 0);
    add(0, 4'b1111, 4'b1000, 1, 4'b0000, 3, 1, 0, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'b0000, 3, 0, 0, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'b0000, 3, 0, 0, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'b0001, 0, 1, 0, 0); // wraps to 0
    add(0, 4'b1111, 4'b0001, 1, 4'b0000, 0, 1, 0, 0);
    add(0, 4'b0000, 4'b1001, 1, 4'b0000, 0, 1, 0, 1); // intruder on 3: proto_err
    add(0, 4'b0000, 4'b0001, 1, 4'b0000, 0, 1, 0, 1); // sticky, owner still busy
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 1);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 1);
    add(0, 4'b0110, 4'b0000, 1, 4'b0010, 1, 1, 0, 1); // arbitration unaffected
    add(0, 4'b0110, 4'b0010, 1, 4'b0000, 1, 1, 0, 1); // BUSY
    add(1, 4'b0110, 4'b0010, 1, 4'b0000, 0, 0, 0, 0); // reset mid-BUSY
    add(0, 4'b0110, 4'b0000, 8, 4'b0010, 1, 1, 0, 0); // lowest active after reset
    add(0, 4'b0000, 4'b0010, 8, 4'b0000, 1, 1, 0, 0);
    add(0, 4'b0000, 4'b0000, 8, 4'b0000, 1, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 8, 4'b0000, 1, 0, 0, 0);

    for (int i = 0; i < nv; i++) begin
      reset       = tv[i].rst;
      req         = tv[i].req;
      driven      = tv[i].drv;
      trn_tbuf_av = tv[i].tb;
      @(negedge trn_clk);
      chk("grant",         i, 32'(grant),         32'(tv[i].g));
      chk("owner",         i, 32'(owner),         32'(tv[i].own));
      chk("busy",          i, 32'(busy),          32'(tv[i].bsy));
      chk("timeout_pulse", i, 32'(timeout_pulse), 32'(tv[i].tp));
      chk("proto_err",     i, 32'(proto_err),     32'(tv[i].pe));
    end

    // Watchdog: grant to requester 2 is never taken up.
    reset  = 1'b0;
    req    = 4'b1100;
    driven = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      @(negedge trn_clk);
      g_log[i]   = grant;
      tp_log[i]  = timeout_pulse;
      own_log[i] = owner;
    end
    gcnt = 0;
    tcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (g_log[i] == 4'b0100) gcnt++;
      if (tp_log[i]) tcnt++;
    end
    chk("to_grant_cycles", 100, 32'(gcnt),      32'd8);
    chk("to_pulse_count",  101, 32'(tcnt),      32'd1);
    chk("to_pulse_pos",    102, 32'(tp_log[8]), 32'd1);
    chk("to_last_grant",   103, 32'(g_log[7]),  32'h4);
    chk("to_next_grant",   104, 32'(g_log[10]), 32'h8);
    chk("to_next_owner",   105, 32'(own_log[10]), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
